// File: rtl/sr_reg_pkg.sv
// Shared types and defaults for the SR register bank.
package sr_reg_pkg;

   // How a channel resolves a simultaneous set and reset request.
   typedef enum logic [1:0] {
      SR_MODE_HOLD    = 2'd0,
      SR_MODE_SET_DOM = 2'd1,
      SR_MODE_RST_DOM = 2'd2,
      SR_MODE_TOGGLE  = 2'd3
   } sr_mode_t;

   localparam int SR_CNT_W_DEF = 8;

endpackage

// File: rtl/sr_cell.sv
// One SR channel: registered state, rising-edge pulse and sticky conflict flag.
module sr_cell
   import sr_reg_pkg::*;
#(
   parameter sr_mode_t MODE    = SR_MODE_HOLD,
   parameter logic     RST_BIT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic s,
   input  logic r,
   input  logic clr_err,
   output logic q,
   output logic q_rise,
   output logic conflict_flag
);

   logic r_q;
   logic r_rise;
   logic r_flag;
   logic w_q_nxt;
   logic w_conflict;

   assign w_conflict = en & s & r;

   always_comb begin
      w_q_nxt = r_q;
      if (en) begin
         case ({s, r})
            2'b10:   w_q_nxt = 1'b1;
            2'b01:   w_q_nxt = 1'b0;
            2'b11: begin
               case (MODE)
                  SR_MODE_SET_DOM: w_q_nxt = 1'b1;
                  SR_MODE_RST_DOM: w_q_nxt = 1'b0;
                  SR_MODE_TOGGLE:  w_q_nxt = ~r_q;
                  default:         w_q_nxt = r_q;
               endcase
            end
            default: w_q_nxt = r_q;
         endcase
      end
   end

   // Clear takes effect before a same-edge conflict is captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q    <= RST_BIT;
         r_rise <= 1'b0;
         r_flag <= 1'b0;
      end else begin
         r_q    <= w_q_nxt;
         r_rise <= ~r_q & w_q_nxt;
         r_flag <= (r_flag & ~clr_err) | w_conflict;
      end
   end

   assign q             = r_q;
   assign q_rise        = r_rise;
   assign conflict_flag = r_flag;

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of N independent SR channels with a shared saturating conflict counter.
module sr_reg_bank
   import sr_reg_pkg::*;
#(
   parameter int             N       = 8,
   parameter sr_mode_t       MODE    = SR_MODE_HOLD,
   parameter logic [N-1:0]   RST_VAL = {N{1'b1}},
   parameter int             CNT_W   = SR_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     s,
   input  logic [N-1:0]     r,
   input  logic             clr_err,
   output logic [N-1:0]     q,
   output logic [N-1:0]     q_rise,
   output logic [N-1:0]     conflict_flag,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_cnt;
   logic             w_any_conflict;

   assign w_any_conflict = en & (|(s & r));

   for (genvar i = 0; i < N; i++) begin : g_cell
      sr_cell #(
         .MODE    (MODE),
         .RST_BIT (RST_VAL[i])
      ) u_cell (
         .clk           (clk),
         .rst           (rst),
         .en            (en),
         .s             (s[i]),
         .r             (r[i]),
         .clr_err       (clr_err),
         .q             (q[i]),
         .q_rise        (q_rise[i]),
         .conflict_flag (conflict_flag[i])
      );
   end

   // A clear coinciding with a new conflict leaves the count at exactly one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr_err) begin
         r_cnt <= w_any_conflict ? CNT_W'(1) : '0;
      end else if (w_any_conflict && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed checks of sr_reg_bank across the four resolution modes.
module tb_sr_reg_bank;
   import sr_reg_pkg::*;

   logic       clk = 1'b0;
   logic       rst, en, clr_err;
   logic [7:0] s, r;

   logic [7:0] q_h, rise_h, flag_h;
   logic [2:0] cnt_h;
   logic [7:0] q_s, rise_s, flag_s;
   logic [7:0] cnt_s;
   logic [7:0] q_d, rise_d, flag_d;
   logic [7:0] cnt_d;
   logic [7:0] q_t, rise_t, flag_t;
   logic [7:0] cnt_t;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sr_reg_bank #(.N(8), .MODE(SR_MODE_HOLD), .RST_VAL(8'hA5), .CNT_W(3)) u_hold (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
      .q(q_h), .q_rise(rise_h), .conflict_flag(flag_h), .conflict_cnt(cnt_h));

   sr_reg_bank #(.N(8), .MODE(SR_MODE_SET_DOM), .RST_VAL(8'hFF), .CNT_W(8)) u_set (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
      .q(q_s), .q_rise(rise_s), .conflict_flag(flag_s), .conflict_cnt(cnt_s));

   sr_reg_bank #(.N(8), .MODE(SR_MODE_RST_DOM), .RST_VAL(8'hFF), .CNT_W(8)) u_rdom (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
      .q(q_d), .q_rise(rise_d), .conflict_flag(flag_d), .conflict_cnt(cnt_d));

   sr_reg_bank #(.N(8), .MODE(SR_MODE_TOGGLE), .RST_VAL(8'hFF), .CNT_W(8)) u_tog (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
      .q(q_t), .q_rise(rise_t), .conflict_flag(flag_t), .conflict_cnt(cnt_t));

   typedef struct {
      logic       rst;
      logic       en;
      logic [7:0] s;
      logic [7:0] r;
      logic       clr;
      logic [7:0] q;
      logic [7:0] rise;
      logic [7:0] flag;
      logic [2:0] cnt;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic i_rst, input logic i_en, input logic [7:0] i_s,
                        input logic [7:0] i_r, input logic i_clr);
      rst     = i_rst;
      en      = i_en;
      s       = i_s;
      r       = i_r;
      clr_err = i_clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; s = '0; r = '0; clr_err = 1'b0;

      //             rst  en   s      r      clr   q      rise   flag   cnt
      tv.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 3'd0});
      tv.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 3'd0});
      tv.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 3'd0});
      tv.push_back('{1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 8'hA4, 8'h00, 8'h00, 3'd0});
      tv.push_back('{1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 8'hA5, 8'h01, 8'h00, 3'd0});
      tv.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 3'd0});
      tv.push_back('{1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 8'hA4, 8'h00, 8'h00, 3'd0});
      tv.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'hA4, 8'h00, 8'h00, 3'd0});
      tv.push_back('{1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 8'hA4, 8'h00, 8'h00, 3'd0});
      tv.push_back('{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'hA4, 8'h00, 8'h00, 3'd0});
      for (int k = 1; k <= 10; k++)
         tv.push_back('{1'b0, 1'b1, 8'h24, 8'h24, 1'b0, 8'hA4, 8'h00, 8'h24,
                        (k > 7) ? 3'd7 : 3'(k)});
      tv.push_back('{1'b0, 1'b1, 8'h02, 8'h02, 1'b1, 8'hA4, 8'h00, 8'h02, 3'd1});
      tv.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'hA4, 8'h00, 8'h00, 3'd0});
      tv.push_back('{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'h5B, 8'h00, 3'd0});
      tv.push_back('{1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00, 8'h00, 3'd0});
      tv.push_back('{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 8'h00, 3'd0});
      tv.push_back('{1'b1, 1'b1, 8'h00, 8'hFF, 1'b1, 8'hA5, 8'h00, 8'h00, 3'd0});
      tv.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 3'd0});

      foreach (tv[i]) begin
         drive(tv[i].rst, tv[i].en, tv[i].s, tv[i].r, tv[i].clr);
         chk($sformatf("row%0d q", i),    32'(q_h),    32'(tv[i].q));
         chk($sformatf("row%0d rise", i), 32'(rise_h), 32'(tv[i].rise));
         chk($sformatf("row%0d flag", i), 32'(flag_h), 32'(tv[i].flag));
         chk($sformatf("row%0d cnt", i),  32'(cnt_h),  32'(tv[i].cnt));
      end

      // Mode resolution from a common 0F starting point.
      drive(1'b0, 1'b1, 8'h0F, 8'hF0, 1'b0);
      chk("mode_pre hold", 32'(q_h), 32'h0F);
      chk("mode_pre set",  32'(q_s), 32'h0F);
      chk("mode_pre rdom", 32'(q_d), 32'h0F);
      chk("mode_pre tog",  32'(q_t), 32'h0F);
      drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
      chk("mode hold q",   32'(q_h),    32'h0F);
      chk("mode set q",    32'(q_s),    32'hFF);
      chk("mode set rise", 32'(rise_s), 32'hF0);
      chk("mode rdom q",   32'(q_d),    32'h00);
      chk("mode tog q",    32'(q_t),    32'hF0);
      chk("mode tog rise", 32'(rise_t), 32'hF0);
      chk("mode set flag", 32'(flag_s), 32'hFF);
      drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
      chk("mode tog2 q",    32'(q_t),    32'h0F);
      chk("mode tog2 rise", 32'(rise_t), 32'h0F);
      chk("mode hold2 q",   32'(q_h),    32'h0F);

      // Reset in mid-operation with RST_VAL all ones.
      drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
      for (int k = 0; k < 5; k++)
         drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
      drive(1'b0, 1'b1, 8'h00, 8'hFF, 1'b0);
      chk("mid pre q",   32'(q_s),   32'h00);
      chk("mid pre cnt", 32'(cnt_s), 32'd5);
      drive(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0);
      chk("mid rst q",    32'(q_s),    32'hFF);
      chk("mid rst rise", 32'(rise_s), 32'h00);
      chk("mid rst cnt",  32'(cnt_s),  32'd0);
      chk("mid rst flag", 32'(flag_s), 32'h00);
      drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
      chk("mid post q",    32'(q_s),    32'hFF);
      chk("mid post rise", 32'(rise_s), 32'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
